decode_ctrl_stage: RTL and testbench

Registered successor to the combinational decode controller. It accepts a 32-bit instruction and PC under valid/ready and fully decodes the opcode, funct3 and funct7 fields into a control bundle. Results are held in a 2-entry skid buffer, so the output is registered without a combinational ready path. The block sits between the IF/ID register and the execute stage. It adds illegal-instruction detection, optional M-extension decode, rd=x0 write suppression and pipeline flush.

---
 rtl/decode_ctrl_stage_pkg.sv | 87 ++++++++
 rtl/decode_ctrl_stage_dec_ctrl_comb.sv | 119 +++++++++++
 rtl/decode_ctrl_stage.sv | 122 ++++++++++++
 tb/tb_decode_ctrl_stage.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_stage_pkg.sv
// Shared types and constants for the registered decode stage.
// Holds the opcode/funct7 constants, the control-bundle field enums, the
// dec_ctrl_t bundle with its NOP value, the skid-buffer state type and
// funct3-to-operation helpers used by the combinational decoder.
package decode_ctrl_stage_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_ALUIMM = 7'b0010011;
  localparam logic [6:0] OPCODE_ALUREG = 7'b0110011;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASS_B, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
    ALU_BGEU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU,
    ALU_REM, ALU_REMU
  } ex_func_t;

  typedef enum logic {RS1_VALUE, PC_VALUE}  rs1_sel_t;
  typedef enum logic {RS2_VALUE, IMM_VALUE} rs2_sel_t;
  typedef enum logic [1:0] {WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC_4} wb_source_type;
  typedef enum logic [1:0] {PC_SRC_NONE, PC_SRC_PC_IMM, PC_SRC_ALU} wb_pc_source_type;

  typedef struct packed {
    ex_func_t         ex_func;
    rs1_sel_t         rs1_sel;
    rs2_sel_t         rs2_sel;
    logic             memwrite_en;
    logic             memread_en;
    logic             branch;
    logic             jmp;
    logic             wb_en;
    wb_source_type    wb_src;
    wb_pc_source_type wb_pc_src;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
  } dec_ctrl_t;

  localparam dec_ctrl_t DEC_CTRL_NOP = '{
    ex_func: ALU_ADD, rs1_sel: RS1_VALUE, rs2_sel: RS2_VALUE,
    memwrite_en: 1'b0, memread_en: 1'b0, branch: 1'b0, jmp: 1'b0, wb_en: 1'b0,
    wb_src: WB_SRC_ALU, wb_pc_src: PC_SRC_NONE,
    rd: 5'd0, rs1: 5'd0, rs2: 5'd0, funct3: 3'd0
  };

  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_t;

  function automatic ex_func_t base_alu_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic ex_func_t muldiv_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_MUL;
      3'd1:    return ALU_MULH;
      3'd2:    return ALU_MULHSU;
      3'd3:    return ALU_MULHU;
      3'd4:    return ALU_DIV;
      3'd5:    return ALU_DIVU;
      3'd6:    return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_dec_ctrl_comb.sv
// Pure combinational instruction decoder.
// Ports: instr (raw 32-bit instruction) in; ctrl (decoded bundle) and
// illegal (encoding not recognised) out. M_EXT_EN enables MUL/DIV decode.
// Illegal encodings collapse to the NOP bundle; the register index and
// funct3 fields always carry the raw instruction bits.
module dec_ctrl_comb
  import decode_ctrl_stage_pkg::*;
#(
  parameter bit M_EXT_EN = 1'b0
) (
  input  logic [31:0] instr,
  output dec_ctrl_t   ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ill;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl = DEC_CTRL_NOP;
    ill  = 1'b0;
    case (opcode)
      OPCODE_LUI: begin
        ctrl.ex_func = ALU_PASS_B;
        ctrl.rs2_sel = IMM_VALUE;
        ctrl.wb_en   = 1'b1;
      end
      OPCODE_AUIPC: begin
        ctrl.rs1_sel = PC_VALUE;
        ctrl.rs2_sel = IMM_VALUE;
        ctrl.wb_en   = 1'b1;
      end
      OPCODE_JAL: begin
        ctrl.rs1_sel   = PC_VALUE;
        ctrl.rs2_sel   = IMM_VALUE;
        ctrl.jmp       = 1'b1;
        ctrl.wb_en     = 1'b1;
        ctrl.wb_src    = WB_SRC_PC_4;
        ctrl.wb_pc_src = PC_SRC_PC_IMM;
      end
      OPCODE_JALR: begin
        ill            = (funct3 != 3'd0);
        ctrl.rs2_sel   = IMM_VALUE;
        ctrl.jmp       = 1'b1;
        ctrl.wb_en     = 1'b1;
        ctrl.wb_src    = WB_SRC_PC_4;
        ctrl.wb_pc_src = PC_SRC_ALU;
      end
      OPCODE_BRANCH: begin
        ctrl.branch    = 1'b1;
        ctrl.wb_pc_src = PC_SRC_PC_IMM;
        case (funct3)
          3'd0:    ctrl.ex_func = ALU_BEQ;
          3'd1:    ctrl.ex_func = ALU_BNE;
          3'd4:    ctrl.ex_func = ALU_BLT;
          3'd5:    ctrl.ex_func = ALU_BGE;
          3'd6:    ctrl.ex_func = ALU_BLTU;
          3'd7:    ctrl.ex_func = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPCODE_LOAD: begin
        ill             = (funct3 == 3'd3) || (funct3 >= 3'd6);
        ctrl.rs2_sel    = IMM_VALUE;
        ctrl.memread_en = 1'b1;
        ctrl.wb_en      = 1'b1;
        ctrl.wb_src     = WB_SRC_MEM;
      end
      OPCODE_STORE: begin
        ill              = (funct3 >= 3'd3);
        ctrl.rs2_sel     = IMM_VALUE;
        ctrl.memwrite_en = 1'b1;
      end
      OPCODE_ALUIMM: begin
        ctrl.rs2_sel = IMM_VALUE;
        ctrl.wb_en   = 1'b1;
        ctrl.ex_func = base_alu_op(funct3);
        // Only the shift immediates use funct7; other funct3 values carry imm bits there.
        if (funct3 == 3'd1) begin
          ill = (funct7 != FUNCT7_BASE);
        end else if (funct3 == 3'd5) begin
          if (funct7 == FUNCT7_ALT) ctrl.ex_func = ALU_SRA;
          else if (funct7 != FUNCT7_BASE) ill = 1'b1;
        end
      end
      OPCODE_ALUREG: begin
        ctrl.wb_en = 1'b1;
        if (funct7 == FUNCT7_BASE) begin
          ctrl.ex_func = base_alu_op(funct3);
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'd0) ctrl.ex_func = ALU_SUB;
          else if (funct3 == 3'd5) ctrl.ex_func = ALU_SRA;
          else ill = 1'b1;
        end else if (funct7 == FUNCT7_MULDIV && M_EXT_EN) begin
          ctrl.ex_func = muldiv_op(funct3);
        end else begin
          ill = 1'b1;
        end
      end
      OPCODE_FENCE, OPCODE_SYSTEM: ;
      default: ill = 1'b1;
    endcase

    if (ill) ctrl = DEC_CTRL_NOP;
    ctrl.rd     = instr[11:7];
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    ctrl.funct3 = funct3;
    if (ctrl.rd == 5'd0) ctrl.wb_en = 1'b0;
    illegal = ill;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: decodes instr_i/pc_i on accept and holds the
// result in a skid buffer of up to two entries in front of execute.
// Ports: clk_i, rst_ni (async, active low); in_valid_i/in_ready_o with
// instr_i and pc_i; flush_i drops everything; out_valid_o/out_ready_i with
// ctrl_o, pc_o and illegal_o describing the head entry.
//
// state     | meaning
// BUF_EMPTY | no entry held, output invalid
// BUF_ONE   | head entry valid, skid slot free
// BUF_FULL  | head and skid entries valid, input stalled
module decode_ctrl_stage
  import decode_ctrl_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int M_EXT_EN   = 0,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output dec_ctrl_t       ctrl_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal_o
);

  buf_state_t      state_q, state_d;
  dec_ctrl_t       dec_ctrl, head_ctrl_q, skid_ctrl_q;
  logic            dec_illegal, head_ill_q, skid_ill_q;
  logic [XLEN-1:0] head_pc_q, skid_pc_q;
  logic            ready_q, accept, pop;
  logic            load_head_in, load_head_skid, load_skid;

  dec_ctrl_comb #(.M_EXT_EN(M_EXT_EN != 0)) u_dec (
    .instr   (instr_i),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Single-entry build trades the registered ready for a pass-through on out_ready_i.
  assign in_ready_o  = (SKID_DEPTH == 1) ? ((state_q == BUF_EMPTY) || out_ready_i) : ready_q;
  assign out_valid_o = (state_q != BUF_EMPTY);
  assign accept      = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign ctrl_o      = head_ctrl_q;
  assign pc_o        = head_pc_q;
  assign illegal_o   = out_valid_o && head_ill_q;

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: if (accept) begin
          state_d      = BUF_ONE;
          load_head_in = 1'b1;
        end
        BUF_ONE: begin
          if (accept && pop) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_d   = BUF_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: if (pop) begin
          state_d        = BUF_ONE;
          load_head_skid = 1'b1;
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BUF_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != BUF_FULL);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_ctrl_q <= DEC_CTRL_NOP;
      head_pc_q   <= '0;
      head_ill_q  <= 1'b0;
      skid_ctrl_q <= DEC_CTRL_NOP;
      skid_pc_q   <= '0;
      skid_ill_q  <= 1'b0;
    end else begin
      if (load_head_in) begin
        head_ctrl_q <= dec_ctrl;
        head_pc_q   <= pc_i;
        head_ill_q  <= dec_illegal;
      end else if (load_head_skid) begin
        head_ctrl_q <= skid_ctrl_q;
        head_pc_q   <= skid_pc_q;
        head_ill_q  <= skid_ill_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= dec_ctrl;
        skid_pc_q   <= pc_i;
        skid_ill_q  <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: one instance with MUL/DIV
// decode enabled and one without, driven by identical stimulus, each
// compared against an instruction-level decode model and a FIFO scoreboard.
module tb_decode_ctrl_stage;
  import decode_ctrl_stage_pkg::*;

  typedef struct packed {
    dec_ctrl_t   ctrl;
    logic [31:0] pc;
    logic        ill;
  } entry_t;

  localparam ex_func_t ALU_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam ex_func_t MUL_TAB [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  localparam ex_func_t BR_TAB  [8] = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;

  logic        in_ready_m, out_valid_m, illegal_m;
  logic        in_ready_b, out_valid_b, illegal_b;
  dec_ctrl_t   ctrl_m, ctrl_b;
  logic [31:0] pc_m, pc_b;

  int checks = 0;
  int failures = 0;
  entry_t q_m[$];
  entry_t q_b[$];

  always #5 clk = ~clk;

  decode_ctrl_stage #(.XLEN(32), .M_EXT_EN(1), .SKID_DEPTH(2)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_m),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid_m),
    .out_ready_i(out_ready), .ctrl_o(ctrl_m), .pc_o(pc_m), .illegal_o(illegal_m)
  );

  decode_ctrl_stage #(.XLEN(32), .M_EXT_EN(0), .SKID_DEPTH(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready), .ctrl_o(ctrl_b), .pc_o(pc_b), .illegal_o(illegal_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference decode, written per instruction class.
  function automatic void golden(input logic [31:0] ins, input bit mext,
                                 output dec_ctrl_t c, output logic ill);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    c = DEC_CTRL_NOP;
    ill = 1'b0;
    case (op)
      7'h37: begin c.ex_func = ALU_PASS_B; c.rs2_sel = IMM_VALUE; c.wb_en = 1'b1; end
      7'h17: begin c.rs1_sel = PC_VALUE; c.rs2_sel = IMM_VALUE; c.wb_en = 1'b1; end
      7'h6F: begin
        c.rs1_sel = PC_VALUE; c.rs2_sel = IMM_VALUE; c.jmp = 1'b1; c.wb_en = 1'b1;
        c.wb_src = WB_SRC_PC_4; c.wb_pc_src = PC_SRC_PC_IMM;
      end
      7'h67: begin
        ill = (f3 != 3'd0);
        c.rs2_sel = IMM_VALUE; c.jmp = 1'b1; c.wb_en = 1'b1;
        c.wb_src = WB_SRC_PC_4; c.wb_pc_src = PC_SRC_ALU;
      end
      7'h63: begin
        ill = (f3 == 3'd2) || (f3 == 3'd3);
        c.branch = 1'b1; c.wb_pc_src = PC_SRC_PC_IMM; c.ex_func = BR_TAB[f3];
      end
      7'h03: begin
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        c.rs2_sel = IMM_VALUE; c.memread_en = 1'b1; c.wb_en = 1'b1; c.wb_src = WB_SRC_MEM;
      end
      7'h23: begin
        ill = (f3 > 3'd2);
        c.rs2_sel = IMM_VALUE; c.memwrite_en = 1'b1;
      end
      7'h13: begin
        ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        c.rs2_sel = IMM_VALUE; c.wb_en = 1'b1;
        c.ex_func = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : ALU_TAB[f3];
      end
      7'h33: begin
        c.wb_en = 1'b1;
        if (f7 == 7'h00) c.ex_func = ALU_TAB[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) c.ex_func = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) c.ex_func = ALU_SRA;
        else if (f7 == 7'h01 && mext) c.ex_func = MUL_TAB[f3];
        else ill = 1'b1;
      end
      7'h0F, 7'h73: ;
      default: ill = 1'b1;
    endcase
    if (ill) c = DEC_CTRL_NOP;
    c.rd = ins[11:7];
    c.rs1 = ins[19:15];
    c.rs2 = ins[24:20];
    c.funct3 = f3;
    if (c.rd == 5'd0) c.wb_en = 1'b0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    r   = $urandom();
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: return {r[31:12], rd, 7'h37};
      1: return {r[31:12], rd, 7'h17};
      2: return {r[31:12], rd, 7'h6F};
      3: return {r[31:20], rs1, 3'd0, rd, 7'h67};
      4: begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 >= 3'd2) f3 = f3 + 3'd2;
        return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
      end
      5: begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 >= 3'd3) f3 = f3 + 3'd1;
        return {r[31:20], rs1, f3, rd, 7'h03};
      end
      6: return {r[31:25], rs2, rs1, 3'($urandom_range(0, 2)), r[11:7], 7'h23};
      7: begin
        f7 = r[31:25];
        if (f3 == 3'd1) f7 = 7'h00;
        if (f3 == 3'd5) f7 = r[0] ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h13};
      end
      8: begin
        case ($urandom_range(0, 2))
          0: f7 = 7'h00;
          1: begin f7 = 7'h20; f3 = r[0] ? 3'd5 : 3'd0; end
          default: f7 = 7'h01;
        endcase
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      default: return r[0] ? 32'h0000000F : 32'h00000073;
    endcase
  endfunction

  task automatic check_side(input string tag, input int n, input entry_t head,
                            input logic ov, input logic ir, input dec_ctrl_t c,
                            input logic [31:0] po, input logic il);
    chk({tag, "_out_valid"}, ov, n > 0);
    chk({tag, "_in_ready"}, ir, n < 2);
    if (n > 0) begin
      chk({tag, "_ctrl"}, c, head.ctrl);
      chk({tag, "_pc"}, po, head.pc);
      chk({tag, "_illegal"}, il, head.ill);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic fl, input logic rdy);
    entry_t    e_m, e_b, h_m, h_b;
    dec_ctrl_t c;
    logic      il;
    bit        acc_m, acc_b, pop_m, pop_b;
    in_valid = v; instr = ins; pc = p; flush = fl; out_ready = rdy;
    @(negedge clk);
    h_m = (q_m.size() > 0) ? q_m[0] : '0;
    h_b = (q_b.size() > 0) ? q_b[0] : '0;
    check_side("m", q_m.size(), h_m, out_valid_m, in_ready_m, ctrl_m, pc_m, illegal_m);
    check_side("b", q_b.size(), h_b, out_valid_b, in_ready_b, ctrl_b, pc_b, illegal_b);
    golden(ins, 1'b1, c, il);
    e_m = '{ctrl: c, pc: p, ill: il};
    golden(ins, 1'b0, c, il);
    e_b = '{ctrl: c, pc: p, ill: il};
    acc_m = v && (q_m.size() < 2);
    acc_b = v && (q_b.size() < 2);
    pop_m = rdy && (q_m.size() > 0);
    pop_b = rdy && (q_b.size() > 0);
    if (fl) begin
      q_m.delete();
      q_b.delete();
    end else begin
      if (pop_m) void'(q_m.pop_front());
      if (pop_b) void'(q_b.pop_front());
      if (acc_m) q_m.push_back(e_m);
      if (acc_b) q_b.push_back(e_b);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] bad [3];
    bad[0] = 32'h00000000;
    bad[1] = 32'h40109093;
    bad[2] = 32'h000090E7;

    // Power-on reset
    #2;
    chk("rst_out_valid", out_valid_m, 1'b0);
    chk("rst_illegal", illegal_m, 1'b0);
    chk("rst_ctrl", ctrl_m, DEC_CTRL_NOP);
    chk("rst_pc", pc_m, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted mid-stream with a full buffer
    step(1'b1, 32'h0080A283, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'h44, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid_m", out_valid_m, 1'b0);
    chk("midrst_out_valid_b", out_valid_b, 1'b0);
    q_m.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready_m, 1'b1);
    @(posedge clk);
    #1;

    // ADD x3,x1,x2
    step(1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b1);
    chk("add_valid", out_valid_m, 1'b1);
    chk("add_func", ctrl_m.ex_func, ALU_ADD);
    chk("add_wb_en", ctrl_m.wb_en, 1'b1);
    chk("add_rd", ctrl_m.rd, 5'd3);
    chk("add_illegal", illegal_m, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // MUL x3,x1,x2 with and without the M extension
    step(1'b1, 32'h022081B3, 32'h104, 1'b0, 1'b1);
    chk("mul_func_m", ctrl_m.ex_func, ALU_MUL);
    chk("mul_illegal_m", illegal_m, 1'b0);
    chk("mul_illegal_b", illegal_b, 1'b1);
    chk("mul_wb_en_b", ctrl_b.wb_en, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Backpressure: LW x5,8(x1) then ADDI x0,x0,0
    step(1'b1, 32'h0080A283, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'h204, 1'b0, 1'b0);
    chk("bp_in_ready", in_ready_m, 1'b0);
    chk("bp_head_memread", ctrl_m.memread_en, 1'b1);
    chk("bp_head_wbsrc", ctrl_m.wb_src, WB_SRC_MEM);
    step(1'b1, 32'h00100093, 32'h208, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("bp_second_valid", out_valid_m, 1'b1);
    chk("bp_second_wb_en", ctrl_m.wb_en, 1'b0);
    chk("bp_second_pc", pc_m, 32'h204);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush with one entry held and an input accepted the same cycle
    step(1'b1, 32'h002081B3, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00500113, 32'h304, 1'b1, 1'b0);
    chk("flush1_valid", out_valid_m, 1'b0);
    chk("flush1_ready", in_ready_m, 1'b1);
    // Flush of a full buffer while an input is offered
    step(1'b1, 32'h002081B3, 32'h310, 1'b0, 1'b0);
    step(1'b1, 32'h0080A283, 32'h314, 1'b0, 1'b0);
    step(1'b1, 32'h00500113, 32'h318, 1'b1, 1'b0);
    chk("flush2_valid", out_valid_m, 1'b0);
    chk("flush2_ready", in_ready_m, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Illegal encodings
    for (int i = 0; i < 3; i++) begin
      step(1'b1, bad[i], 32'h400 + 32'(i * 4), 1'b0, 1'b1);
      chk("bad_illegal", illegal_m, 1'b1);
      chk("bad_enables", {ctrl_m.memwrite_en, ctrl_m.memread_en, ctrl_m.wb_en,
                          ctrl_m.branch, ctrl_m.jmp}, 5'b0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // AUIPC x5,0x12345
    step(1'b1, 32'h12345297, 32'h500, 1'b0, 1'b1);
    chk("auipc_func", ctrl_m.ex_func, ALU_ADD);
    chk("auipc_rs1", ctrl_m.rs1_sel, PC_VALUE);
    chk("auipc_rs2", ctrl_m.rs2_sel, IMM_VALUE);
    chk("auipc_wbsrc", ctrl_m.wb_src, WB_SRC_ALU);
    chk("auipc_jmp", ctrl_m.jmp, 1'b0);
    chk("auipc_pcsrc", ctrl_m.wb_pc_src, PC_SRC_NONE);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Random stream with random backpressure and occasional flush
    for (int i = 0; i < 100; i++) begin
      logic v, rdy, fl;
      v   = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 24) == 0);
      step(v, rand_instr(), 32'h1000 + 32'(i * 4), fl, rdy);
    end

    // Full throughput: ready held high, one entry in and out every cycle
    for (int i = 0; i < 30; i++) begin
      step(1'b1, rand_instr(), 32'h2000 + 32'(i * 4), 1'b0, 1'b1);
      chk("tput_valid", out_valid_m, 1'b1);
    end
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
